shift_unit: RTL
===============

# shift_unit

Sequential shift execution stage for the datapath. It accepts shift requests over a valid/ready handshake, decodes the opcode into the `sin`/`shl`/`shamt` controls of the existing combinational `SHIFTER` (SIZE=32), and registers the result. It presents the result downstream over a second valid/ready handshake. Rotates, when compiled in, run as two sequenced passes through the same shifter.

## Interface
Parameters:
- `WIDTH`, 32: datapath width; only 32 is supported.
- `SHW`, 5: shift-amount width, equal to `$clog2(WIDTH)`.

Ports:
- `clk` in 1: the single clock; all state is on its rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `in_valid` in 1: request valid.
- `in_ready` out 1: unit can accept a request.
- `in_op` in 3: opcode. 0 SLL, 1 SRL, 2 SRA, 3 ROL, 4 ROR, 5–7 illegal.
- `in_a` in WIDTH: operand.
- `in_shamt` in SHW: shift amount.
- `out_valid` out 1: result valid.
- `out_ready` in 1: downstream accepts the result.
- `out_res` out WIDTH: result.
- `out_err` out 1: illegal or disabled opcode; qualified by `out_valid`.
- `busy` out 1: state is not IDLE.

## Operation
- A request is accepted on a rising edge where `in_valid && in_ready`. On acceptance the unit latches `op`, `a` and `shamt` into operand registers.
- Shifter controls are derived from the latched operands:
  - SLL: `sin=0`, `shl=1`.
  - SRL: `sin=0`, `shl=0`.
  - SRA: `sin=a[31]`, `shl=0`.
- FSM states: IDLE, PASS1, PASS2, DONE.
  - IDLE → PASS1 on accept.
  - PASS1, SLL/SRL/SRA: the shifter output is registered into `out_res`. Next state is DONE.
  - PASS1, ROR: `a>>shamt` (logical) is stored in the partial register. Next state is PASS2.
  - PASS1, ROL: `a<<shamt` is stored in the partial register. Next state is PASS2.
  - PASS1, illegal opcode: `out_res=0` and `out_err=1`. Next state is DONE.
  - PASS2, ROR: `out_res = partial | (a << (0-shamt))`, where the subtraction is mod 32.
  - PASS2, ROL: `out_res = partial | (a >> (0-shamt))`, where the subtraction is mod 32.
  - PASS2 → DONE.
  - DONE: `out_valid=1`. `out_res` and `out_err` are held stable until `out_valid && out_ready`.
  - DONE → IDLE when `out_ready` is high and there is no new accept.
  - DONE → PASS1 when `out_ready && in_valid`: the result is handed off and the new request is accepted on the same edge.
- `in_ready = (state==IDLE) | (state==DONE & out_ready)`.
- Rotate by 0: the complement amount is also 0, so the result equals `a`. No special case is needed.
- Shift by 31 is legal. Shift amounts of 32 or more are unrepresentable.
- Reset (asynchronous, at any time, including mid-rotate) forces:
  - state to IDLE;
  - `out_valid=0`, `out_err=0`, `out_res=0`;
  - the partial register and operand registers to 0;
  - `busy=0`, `in_ready=1` once `rst_n` is high.
- A request in flight at reset is discarded and is never presented downstream.

## Timing
- Accept at edge T.
- SLL/SRL/SRA/illegal: `out_valid` is high after edge T+1.
- ROL/ROR: `out_valid` is high after edge T+2.
- Peak throughput, with `out_ready` held high:
  - one result every 2 cycles for shifts;
  - one result every 3 cycles for rotates.
- Everything is combinational within one cycle: the shifter path, the complement-amount subtract and the OR. There are no multicycle paths.
- Outputs are registered, except `in_ready`, which depends combinationally on `out_ready`.

## Configuration
- Macro: `SHIFT_UNIT_ROTATE_EN`.
- Defined: ROL and ROR behave as described above, and the PASS2 state and partial register exist.
- Undefined:
  - opcodes 3 and 4 are treated as illegal: `out_err=1`, `out_res=0`, latency 1;
  - the PASS2 state and partial register are not synthesized.

## Structure
- Shared package `shift_pkg` holds:
  - the opcode enum `shift_op_t` (SLL, SRL, SRA, ROL, ROR);
  - the state enum `shift_state_t`;
  - `SHIFT_W=32` and `SHIFT_AW=5`.
- One natural sub-module, `shift_op_decode`: combinational. It maps op, `a[31]` and pass to `sin`, `shl`, the effective `shamt` and the illegal flag.
- `SHIFTER` is instantiated once and shared by both passes.

## Test plan
- Reset release → `in_ready=1`, `out_valid=0`, `out_res=0`, `busy=0`.
- SRA, `a=0x8000_0000`, `shamt=4` → `out_res=0xF800_0000` after edge T+1. SLL, `a=0x0000_0001`, `shamt=31` → `0x8000_0000`. SRL, `a=0xF000_0000`, `shamt=28` → `0x0000_000F`.
- With the macro defined:
  - ROR, `a=0x1234_5678`, `shamt=8` → `0x7812_3456` after edge T+2;
  - ROL, same `a` and `shamt` → `0x3456_7812`;
  - ROR with `shamt=0` → `0x1234_5678`.
- Without the macro: `op=4` → `out_err=1`, `out_res=0` after edge T+1. With either build, `op=7` gives the same response.
- Backpressure: hold `out_ready=0` for 3 cycles in DONE → `out_res` is stable and `in_ready=0`. Then raise `out_ready` with a new `in_valid` → the handoff and the new accept occur on the same edge.
- Drive `rst_n` low during PASS2 of a rotate → `out_valid` is never asserted for that request, and the state is IDLE immediately.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared types and constants for the shift execution stage.
// Optional feature macro: SHIFT_UNIT_ROTATE_EN (enables ROL/ROR).
package shift_pkg;

  localparam int SHIFT_W  = 32;
  localparam int SHIFT_AW = 5;

  typedef enum logic [2:0] {
    OP_SLL = 3'd0,
    OP_SRL = 3'd1,
    OP_SRA = 3'd2,
    OP_ROL = 3'd3,
    OP_ROR = 3'd4
  } shift_op_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PASS1 = 2'd1,
    ST_PASS2 = 2'd2,
    ST_DONE  = 2'd3
  } shift_state_t;

endpackage

// File: rtl/SHIFTER.sv
// Combinational barrel shifter: left shift with zero fill, or right shift
// filling vacated bits with sin.
module SHIFTER #(
  parameter int SIZE = 32
) (
  input  logic [SIZE-1:0]         in_i,
  input  logic [$clog2(SIZE)-1:0] shamt_i,
  input  logic                    sin_i,
  input  logic                    shl_i,
  output logic [SIZE-1:0]         out_o
);

  logic [SIZE-1:0] fill_mask;

  // Bits vacated by a right shift get the fill value
  always_comb begin
    fill_mask = ~({SIZE{1'b1}} >> shamt_i);
    if (shl_i) out_o = in_i << shamt_i;
    else       out_o = (in_i >> shamt_i) | (sin_i ? fill_mask : {SIZE{1'b0}});
  end

endmodule

// File: rtl/shift_unit_decode.sv
// Opcode decode: maps op, operand sign bit and pass number onto the
// shifter controls. The second pass of a rotate uses the complement
// amount (0 - shamt mod 32) in the opposite direction.
// Optional feature macro: SHIFT_UNIT_ROTATE_EN.
module shift_op_decode
  import shift_pkg::*;
(
  input  logic [2:0]          op_i,
  input  logic                a_msb_i,
  input  logic                pass2_i,
  input  logic [SHIFT_AW-1:0] shamt_i,
  output logic                sin_o,
  output logic                shl_o,
  output logic [SHIFT_AW-1:0] shamt_o,
  output logic                illegal_o
);

  // Derive shifter controls from the latched request
  always_comb begin
    sin_o     = 1'b0;
    shl_o     = 1'b0;
    illegal_o = 1'b0;
    shamt_o   = pass2_i ? (SHIFT_AW'(0) - shamt_i) : shamt_i;
    case (op_i)
      OP_SLL: shl_o = 1'b1;
      OP_SRL: shl_o = 1'b0;
      OP_SRA: sin_o = a_msb_i;
`ifdef SHIFT_UNIT_ROTATE_EN
      OP_ROL: shl_o = ~pass2_i;
      OP_ROR: shl_o = pass2_i;
`endif
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/shift_unit.sv
// Sequential shift execution stage with valid/ready on both sides.
// Shifts take one pass through the shared SHIFTER; rotates (when
// SHIFT_UNIT_ROTATE_EN is defined) take two passes whose results are ORed.
// Optional feature macro: SHIFT_UNIT_ROTATE_EN.
module shift_unit
  import shift_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [SHW-1:0]   in_shamt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_res,
  output logic             out_err,
  output logic             busy
);

  shift_state_t     state_q;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] a_q;
  logic [SHW-1:0]   shamt_q;
  logic [WIDTH-1:0] res_q;
  logic             err_q;
  logic             valid_q;
  logic             busy_q;
`ifdef SHIFT_UNIT_ROTATE_EN
  logic [WIDTH-1:0] partial_q;
`endif

  logic             sh_sin;
  logic             sh_shl;
  logic [SHW-1:0]   sh_amt;
  logic             op_illegal;
  logic [WIDTH-1:0] sh_out;
  logic             pass2;
  logic             accept;

  assign pass2     = (state_q == ST_PASS2);
  assign in_ready  = (state_q == ST_IDLE) | ((state_q == ST_DONE) & out_ready);
  assign accept    = in_valid & in_ready;
  assign out_valid = valid_q;
  assign out_res   = res_q;
  assign out_err   = err_q;
  assign busy      = busy_q;

  shift_op_decode u_decode (
    .op_i      (op_q),
    .a_msb_i   (a_q[WIDTH-1]),
    .pass2_i   (pass2),
    .shamt_i   (shamt_q),
    .sin_o     (sh_sin),
    .shl_o     (sh_shl),
    .shamt_o   (sh_amt),
    .illegal_o (op_illegal)
  );

  SHIFTER #(.SIZE(WIDTH)) u_shifter (
    .in_i    (a_q),
    .shamt_i (sh_amt),
    .sin_i   (sh_sin),
    .shl_i   (sh_shl),
    .out_o   (sh_out)
  );

  // Request FSM: accept, run one or two shifter passes, hold result until taken
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      op_q      <= 3'd0;
      a_q       <= '0;
      shamt_q   <= '0;
      res_q     <= '0;
      err_q     <= 1'b0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
`ifdef SHIFT_UNIT_ROTATE_EN
      partial_q <= '0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            op_q    <= in_op;
            a_q     <= in_a;
            shamt_q <= in_shamt;
            state_q <= ST_PASS1;
            busy_q  <= 1'b1;
          end
        end
        ST_PASS1: begin
          if (op_illegal) begin
            res_q   <= '0;
            err_q   <= 1'b1;
            valid_q <= 1'b1;
            state_q <= ST_DONE;
          end
`ifdef SHIFT_UNIT_ROTATE_EN
          else if ((op_q == OP_ROL) || (op_q == OP_ROR)) begin
            partial_q <= sh_out;
            state_q   <= ST_PASS2;
          end
`endif
          else begin
            res_q   <= sh_out;
            err_q   <= 1'b0;
            valid_q <= 1'b1;
            state_q <= ST_DONE;
          end
        end
`ifdef SHIFT_UNIT_ROTATE_EN
        ST_PASS2: begin
          res_q   <= partial_q | sh_out;
          err_q   <= 1'b0;
          valid_q <= 1'b1;
          state_q <= ST_DONE;
        end
`endif
        ST_DONE: begin
          if (out_ready) begin
            valid_q <= 1'b0;
            if (in_valid) begin
              op_q    <= in_op;
              a_q     <= in_a;
              shamt_q <= in_shamt;
              state_q <= ST_PASS1;
            end else begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule
